// File: rtl/wavegen_pdm.sv
// Multi-channel waveform generator (saw down/up, triangle, square) with one
// first-order PDM modulator per channel, configured through a shared write port.
module wavegen_pdm #(
   parameter  int NBITS = 10,
   parameter  int NCH   = 4,
   parameter  int DIVW  = 24,
   localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_we,
   input  logic [CHW-1:0]         cfg_ch,
   input  logic [1:0]             cfg_addr,
   input  logic [DIVW-1:0]        cfg_data,
   output logic [NCH-1:0]         pdm_out,
   output logic [NCH*NBITS-1:0]   level,
   output logic [NCH-1:0]         wrap_pulse
);

   typedef enum logic [1:0] {
      MODE_SAW_DOWN = 2'd0,
      MODE_SAW_UP   = 2'd1,
      MODE_TRIANGLE = 2'd2,
      MODE_SQUARE   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      REG_DIV     = 2'd0,
      REG_MODE    = 2'd1,
      REG_EN      = 2'd2,
      REG_RESTART = 2'd3
   } reg_e;

   localparam logic [NBITS-1:0] MAX = '1;

   logic [DIVW-1:0]  div_q  [NCH];
   logic [DIVW-1:0]  cnt_q  [NCH];
   mode_e            mode_q [NCH];
   logic [NBITS-1:0] lvl_q  [NCH];
   logic [NBITS:0]   acc_q  [NCH];
   logic [NCH-1:0]   en_q;
   logic [NCH-1:0]   dir_up_q;

   logic [NCH-1:0]   wr_hit;
   logic [NCH-1:0]   step;
   logic [NBITS-1:0] nxt_lvl [NCH];
   logic [NCH-1:0]   nxt_dir;
   logic [NCH-1:0]   nxt_wrap;
   logic [NBITS:0]   pdm_sum [NCH];

   // A config write to a channel suppresses that channel's step in the same cycle.
   always_comb begin
      for (int n = 0; n < NCH; n++) begin
         wr_hit[n]   = cfg_we && (cfg_ch == CHW'(n));
         step[n]     = en_q[n] && (cnt_q[n] == div_q[n]) && !wr_hit[n];
         nxt_lvl[n]  = lvl_q[n];
         nxt_dir[n]  = dir_up_q[n];
         nxt_wrap[n] = 1'b0;
         pdm_sum[n]  = {1'b0, acc_q[n][NBITS-1:0]} + {1'b0, lvl_q[n]};
         unique case (mode_q[n])
            MODE_SAW_DOWN: begin
               if (lvl_q[n] == '0) begin
                  nxt_lvl[n]  = MAX;
                  nxt_wrap[n] = 1'b1;
               end else begin
                  nxt_lvl[n] = lvl_q[n] - NBITS'(1);
               end
            end
            MODE_SAW_UP: begin
               if (lvl_q[n] == MAX) begin
                  nxt_lvl[n]  = '0;
                  nxt_wrap[n] = 1'b1;
               end else begin
                  nxt_lvl[n] = lvl_q[n] + NBITS'(1);
               end
            end
            MODE_TRIANGLE: begin
               // Turning points bounce immediately so neither 0 nor MAX repeats.
               if (lvl_q[n] == '0) begin
                  nxt_lvl[n]  = NBITS'(1);
                  nxt_dir[n]  = 1'b1;
                  nxt_wrap[n] = 1'b1;
               end else if (dir_up_q[n] && lvl_q[n] == MAX) begin
                  nxt_lvl[n] = MAX - NBITS'(1);
                  nxt_dir[n] = 1'b0;
               end else if (dir_up_q[n]) begin
                  nxt_lvl[n] = lvl_q[n] + NBITS'(1);
               end else begin
                  nxt_lvl[n] = lvl_q[n] - NBITS'(1);
               end
            end
            MODE_SQUARE: begin
               if (lvl_q[n] == MAX) begin
                  nxt_lvl[n] = '0;
               end else begin
                  nxt_lvl[n]  = MAX;
                  nxt_wrap[n] = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NCH; n++) begin
            div_q[n]  <= '0;
            cnt_q[n]  <= '0;
            mode_q[n] <= MODE_SAW_DOWN;
            lvl_q[n]  <= MAX;
            acc_q[n]  <= '0;
         end
         en_q       <= '0;
         dir_up_q   <= '1;
         pdm_out    <= '0;
         wrap_pulse <= '0;
      end else begin
         for (int n = 0; n < NCH; n++) begin
            wrap_pulse[n] <= 1'b0;
            if (en_q[n]) begin
               acc_q[n]   <= pdm_sum[n];
               pdm_out[n] <= pdm_sum[n][NBITS];
            end else begin
               acc_q[n]   <= '0;
               pdm_out[n] <= 1'b0;
            end

            if (wr_hit[n]) begin
               unique case (reg_e'(cfg_addr))
                  REG_DIV: begin
                     div_q[n] <= cfg_data;
                     cnt_q[n] <= '0;
                  end
                  REG_MODE: begin
                     mode_q[n]   <= mode_e'(cfg_data[1:0]);
                     dir_up_q[n] <= 1'b1;
                  end
                  REG_EN: en_q[n] <= cfg_data[0];
                  REG_RESTART: begin
                     cnt_q[n]    <= '0;
                     acc_q[n]    <= '0;
                     dir_up_q[n] <= 1'b1;
                     lvl_q[n]    <= (mode_q[n] == MODE_SAW_DOWN) ? MAX : '0;
                  end
                  default: ;
               endcase
            end else if (step[n]) begin
               cnt_q[n]      <= '0;
               lvl_q[n]      <= nxt_lvl[n];
               dir_up_q[n]   <= nxt_dir[n];
               wrap_pulse[n] <= nxt_wrap[n];
            end else if (en_q[n]) begin
               cnt_q[n] <= cnt_q[n] + DIVW'(1);
            end
         end
      end
   end

   always_comb begin
      level = '0;
      for (int n = 0; n < NCH; n++) level[n*NBITS +: NBITS] = lvl_q[n];
   end

endmodule

// File: tb/tb_wavegen_pdm.sv
// Directed bench for wavegen_pdm with three channels, so that cfg_ch = NCH is
// representable and the out-of-range write can be exercised.
module tb_wavegen_pdm;

   localparam int NBITS = 10;
   localparam int NCH   = 3;
   localparam int DIVW  = 24;
   localparam int CHW   = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  cfg_we;
   logic [CHW-1:0]        cfg_ch;
   logic [1:0]            cfg_addr;
   logic [DIVW-1:0]       cfg_data;
   logic [NCH-1:0]        pdm_out;
   logic [NCH*NBITS-1:0]  level;
   logic [NCH-1:0]        wrap_pulse;

   int vectors     = 0;
   int miscompares = 0;
   int wrap_cnt [NCH];
   int ones_cnt [NCH];

   wavegen_pdm #(.NBITS(NBITS), .NCH(NCH), .DIVW(DIVW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .pdm_out    (pdm_out),
      .level      (level),
      .wrap_pulse (wrap_pulse)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] lvl(input int n);
      return 32'(level[n*NBITS +: NBITS]);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Outputs and inputs both move 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      for (int c = 0; c < NCH; c++) begin
         wrap_cnt[c] = 0;
         ones_cnt[c] = 0;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         for (int c = 0; c < NCH; c++) begin
            wrap_cnt[c] += int'(wrap_pulse[c]);
            ones_cnt[c] += int'(pdm_out[c]);
         end
      end
   endtask

   task automatic write(input logic [CHW-1:0] ch, input logic [1:0] addr, input logic [DIVW-1:0] data);
      cfg_we   = 1'b1;
      cfg_ch   = ch;
      cfg_addr = addr;
      cfg_data = data;
      tick();
      cfg_we   = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      cfg_we   = 1'b0;
      cfg_ch   = '0;
      cfg_addr = '0;
      cfg_data = '0;
      clear_counts();
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("reset_level", 32'(level), {2'b0, 10'd1023, 10'd1023, 10'd1023});
      check("reset_pdm",   32'(pdm_out), 32'd0);
      check("reset_wrap",  32'(wrap_pulse), 32'd0);

      // ch0 saw-down, div 0: one step per cycle, wrap on the 0 -> 1023 step
      write(0, 2, 24'd1);
      check("saw_en_edge", lvl(0), 32'd1023);
      clear_counts();
      run(1);
      check("saw_first", lvl(0), 32'd1022);
      run(1021);
      check("saw_one", lvl(0), 32'd1);
      run(1);
      check("saw_zero", lvl(0), 32'd0);
      check("saw_zero_wrap", 32'(wrap_pulse[0]), 32'd0);
      run(1);
      check("saw_reload", lvl(0), 32'd1023);
      check("saw_reload_wrap", 32'(wrap_pulse[0]), 32'd1);
      check("saw_wrap_count", 32'(wrap_cnt[0]), 32'd1);
      check("saw_others_idle", 32'(level[29:10]), {12'b0, 10'd1023, 10'd1023});
      run(1);
      check("saw_after_wrap", lvl(0), 32'd1022);

      // Divider write while a step is due: write wins, next step 6 cycles on
      write(0, 0, 24'd5);
      check("divwr_no_step", lvl(0), 32'd1022);
      check("divwr_no_wrap", 32'(wrap_pulse[0]), 32'd0);
      run(5);
      check("divwr_hold5", lvl(0), 32'd1022);
      run(1);
      check("divwr_step6", lvl(0), 32'd1021);
      write(0, 2, 24'd0);
      run(1);
      check("dis_level_hold", lvl(0), 32'd1021);
      check("dis_pdm_zero", 32'(pdm_out[0]), 32'd0);

      // Out-of-range channel writes touch nothing
      write(3, 0, 24'hFFFFFF);
      write(3, 1, 24'hFFFFFF);
      write(3, 2, 24'hFFFFFF);
      write(3, 3, 24'hFFFFFF);
      run(3);
      check("oob_level", 32'(level), {2'b0, 10'd1023, 10'd1023, 10'd1021});
      check("oob_pdm",   32'(pdm_out), 32'd0);
      check("oob_wrap",  32'(wrap_pulse), 32'd0);

      // Re-enable resumes with held div=5 and cnt=0
      write(0, 2, 24'd1);
      run(5);
      check("reen_hold5", lvl(0), 32'd1021);
      run(1);
      check("reen_step6", lvl(0), 32'd1020);
      write(0, 2, 24'd0);

      // Square on ch0: a non-extreme level goes to MAX with wrap
      write(0, 1, 24'd3);
      write(0, 0, 24'd0);
      write(0, 2, 24'd1);
      check("sq_mode_keeps_level", lvl(0), 32'd1020);
      run(1);
      check("sq_to_max", lvl(0), 32'd1023);
      check("sq_to_max_wrap", 32'(wrap_pulse[0]), 32'd1);
      run(1);
      check("sq_to_zero", lvl(0), 32'd0);
      check("sq_to_zero_wrap", 32'(wrap_pulse[0]), 32'd0);
      run(1);
      check("sq_max_again", lvl(0), 32'd1023);
      write(0, 2, 24'd0);
      check("sq_dis_hold", lvl(0), 32'd1023);
      check("sq_dis_no_wrap", 32'(wrap_pulse[0]), 32'd0);

      // ch1 triangle, div 3: 0..1023..0 in 2046 steps of 4 cycles
      write(1, 1, 24'd2);
      write(1, 0, 24'd3);
      write(1, 3, 24'd0);
      check("tri_restart", lvl(1), 32'd0);
      write(1, 2, 24'd1);
      clear_counts();
      run(3);
      check("tri_hold3", lvl(1), 32'd0);
      run(1);
      check("tri_first", lvl(1), 32'd1);
      check("tri_first_wrap", 32'(wrap_pulse[1]), 32'd1);
      run(4088);
      check("tri_peak", lvl(1), 32'd1023);
      run(4);
      check("tri_peak_next", lvl(1), 32'd1022);
      run(4088);
      check("tri_floor", lvl(1), 32'd0);
      check("tri_wraps_half", 32'(wrap_cnt[1]), 32'd1);
      run(4);
      check("tri_period", lvl(1), 32'd1);
      check("tri_wraps_full", 32'(wrap_cnt[1]), 32'd2);

      // ch2 saw-up to 256, freeze, then PDM density with a huge divider
      write(2, 1, 24'd1);
      write(2, 3, 24'd0);
      check("up_restart", lvl(2), 32'd0);
      write(2, 2, 24'd1);
      run(256);
      check("up_256", lvl(2), 32'd256);
      write(2, 2, 24'd0);
      check("up_frozen", lvl(2), 32'd256);
      write(2, 0, 24'hFFFFFF);
      write(2, 2, 24'd1);
      clear_counts();
      run(3);
      check("pdm_phase_low", 32'(pdm_out[2]), 32'd0);
      run(1021);
      check("pdm_density", 32'(ones_cnt[2]), 32'd256);
      check("pdm_last_high", 32'(pdm_out[2]), 32'd1);
      check("pdm_level_held", lvl(2), 32'd256);

      // Reset mid-triangle, with a concurrent enable write that must lose
      rst      = 1'b1;
      cfg_we   = 1'b1;
      cfg_ch   = 2'd0;
      cfg_addr = 2'd2;
      cfg_data = 24'd1;
      tick();
      rst    = 1'b0;
      cfg_we = 1'b0;
      check("rst_level", 32'(level), {2'b0, 10'd1023, 10'd1023, 10'd1023});
      check("rst_pdm",   32'(pdm_out), 32'd0);
      check("rst_wrap",  32'(wrap_pulse), 32'd0);
      run(8);
      check("rst_all_disabled", 32'(level), {2'b0, 10'd1023, 10'd1023, 10'd1023});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wavegen_pdm.md
WAVEGEN_PDM -- requirements
Module: wavegen_pdm

Interface
REQ-001 Parameter NBITS, default 10: width of the waveform level and PDM accumulator.
REQ-002 Parameter NCH, default 4: number of independent channels.
REQ-003 Parameter DIVW, default 24: width of each channel's step divider.
REQ-004 clk  input  1  system clock (48 MHz HFOSC domain).
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 cfg_we  input  1  configuration write strobe, single-cycle, sampled on rising clk.
REQ-007 cfg_ch  input  max(1,clog2(NCH))  target channel of a write.
REQ-008 cfg_addr  input  2  register select: 0 divider, 1 mode, 2 enable, 3 phase-restart.
REQ-009 cfg_data  input  DIVW  write data; only the low bits a register needs are used.
REQ-010 pdm_out  output  NCH  registered PDM bitstream, one bit per channel.
REQ-011 level  output  NCH*NBITS  current waveform level; channel n occupies bits [n*NBITS +: NBITS].
REQ-012 wrap_pulse  output  NCH  one-cycle pulse per channel at waveform period boundary.

Function
REQ-013 Per channel: prescale counter cnt (DIVW bits); when enabled and cnt==div, a step fires: cnt<=0 and level advances; otherwise cnt<=cnt+1.
REQ-014 div=0 shall step every cycle; the step period is div+1 clocks.
REQ-015 Mode 0 saw-down: level-1 per step; at 0 the next step loads MAX=2^NBITS-1 and asserts wrap_pulse.
REQ-016 Mode 1 saw-up: level+1 per step; at MAX the next step loads 0 and asserts wrap_pulse.
REQ-017 Mode 2 triangle: internal dir flag; up steps until level==MAX, then dir flips and down steps until 0, then dir flips; wrap_pulse on the step leaving 0 upward; no value repeats at the turning points.
REQ-018 Mode 3 square: each step toggles level between 0 and MAX (any other value goes to MAX); wrap_pulse on the step to MAX.
REQ-019 wrap_pulse is registered, high exactly the cycle level shows the wrapped value, otherwise 0.
REQ-020 PDM: acc (NBITS+1 bits) updates each enabled cycle as acc <= {1'b0,acc[NBITS-1:0]} + level; pdm_out <= carry of that sum; density = level/2^NBITS (MAX gives 1023 ones per 1024 cycles at NBITS=10, 0 gives none).
REQ-021 Latency: level changes 1 cycle after the step condition; pdm_out reflects a new level from the next cycle.
REQ-022 Disabled channel: cnt, level, dir hold; acc clears to 0; pdm_out and wrap_pulse 0.
REQ-023 Write addr 0: div<=cfg_data and cnt<=0 the same cycle; the next step fires div+1 cycles later.
REQ-024 Write addr 1: mode<=cfg_data[1:0]; level preserved; dir set to up; cnt unchanged.
REQ-025 Write addr 2: enable<=cfg_data[0]; re-enable resumes from held level and cnt.
REQ-026 Write addr 3: cnt<=0, acc<=0, dir<=up, level<=MAX if mode 0 else 0; no wrap_pulse.
REQ-027 A write with cfg_ch>=NCH shall be ignored with no side effect.
REQ-028 A write coinciding with a step on the same channel: the write wins; no step, no wrap_pulse that cycle.
REQ-029 Channels are fully independent; simultaneous steps on all channels are legal.

Reset
REQ-030 On rst: div=0, mode=0, enable=0, cnt=0, acc=0, dir=up, level=MAX, pdm_out=0, wrap_pulse=0 on every channel; rst overrides any concurrent cfg_we.
REQ-031 Reset mid-operation returns all channels to the REQ-030 values on the next edge.

Verification
REQ-032 Reset, enable ch0 mode 0 div=0 -> level 1023,1022,...,0,1023; wrap_pulse once per 1024 cycles, coincident with level 1023.
REQ-033 ch1 mode 2, div=3 -> level steps every 4 cycles 0..1023..0; period 2046 steps; no repeat at 0 or 1023.
REQ-034 ch2 mode 1, restart, then freeze at level 256 by disabling, re-enable with div held large -> pdm_out density exactly 256 ones per 1024 cycles.
REQ-035 Write div=5 to ch0 while ch0 step is due -> no step that cycle; next step 6 cycles later.
REQ-036 cfg_ch=NCH write with data 0xFFFFFF -> all registers and outputs unchanged.
REQ-037 Assert rst mid-triangle on ch1 -> next cycle level=1023, pdm_out=0, enable=0 on all channels.
